// File: rtl/alu_cmd_sequencer.sv
// Command-side driver for an 8-bit flag-producing ALU: buffers {opcode,A,B} commands in a FIFO,
// drives each onto the ALU, samples result/flags after a settle delay and returns them.
module alu_cmd_sequencer #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_opcode,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [2:0]       alu_opcode,
   input  logic [7:0]       alu_result,
   input  logic [3:0]       alu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_result,
   output logic [3:0]       rsp_flags,
   input  logic             clr_sticky,
   output logic [1:0]       sticky,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {StIdle, StDrive, StCapture, StResp} state_e;

   state_e          state_q;
   logic [TW-1:0]   timer_q;
   logic [18:0]     mem_q [DEPTH];
   logic [AW-1:0]   wptr_q;
   logic [AW-1:0]   rptr_q;
   logic [AW:0]     count_q;
   logic            push;
   logic            pop;
   logic            capture;
   logic [1:0]      sticky_set;

   assign cmd_ready  = (count_q != (AW+1)'(DEPTH));
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state_q == StIdle) && (count_q != '0);
   assign capture    = (state_q == StCapture);
   assign sticky_set = capture ? {alu_flags[3], alu_flags[0]} : 2'b00;

   // Storage needs no reset: occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= {cmd_opcode, cmd_a, cmd_b};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         op_count   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (pop) begin
                  {alu_opcode, alu_a, alu_b} <= mem_q[rptr_q];
                  timer_q <= TW'(SETTLE - 1);
                  state_q <= StDrive;
               end
            end
            StDrive: begin
               if (timer_q == '0) begin
                  state_q <= StCapture;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            StCapture: begin
               rsp_result <= alu_result;
               rsp_flags  <= alu_flags;
               rsp_valid  <= 1'b1;
               state_q    <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // A flag captured in the same cycle as a clear survives the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky <= 2'b00;
      end else if (clr_sticky) begin
         sticky <= sticky_set;
      end else begin
         sticky <= sticky | sticky_set;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU
// (carry on SUB means borrow).
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_opcode;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_opcode;
   logic [7:0]  alu_result;
   logic [3:0]  alu_flags;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_result;
   logic [3:0]  rsp_flags;
   logic        clr_sticky;
   logic [1:0]  sticky;
   logic [15:0] op_count;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DEPTH(4), .SETTLE(1), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_result (alu_result),
      .alu_flags  (alu_flags),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .clr_sticky (clr_sticky),
      .sticky     (sticky),
      .op_count   (op_count)
   );

   // Behavioural ALU: flags are {carry, zero, negative, overflow}
   logic [8:0] sum9;
   logic [8:0] diff9;
   logic [7:0] res;
   logic       c;
   logic       v;
   always_comb begin
      sum9  = {1'b0, alu_a} + {1'b0, alu_b};
      diff9 = {1'b0, alu_a} - {1'b0, alu_b};
      res   = 8'h00;
      c     = 1'b0;
      v     = 1'b0;
      case (alu_opcode)
         3'b000: begin
            res = sum9[7:0];
            c   = sum9[8];
            v   = (alu_a[7] == alu_b[7]) && (res[7] != alu_a[7]);
         end
         3'b001: begin
            res = diff9[7:0];
            c   = diff9[8];
            v   = (alu_a[7] != alu_b[7]) && (res[7] != alu_a[7]);
         end
         3'b010:  res = alu_a & alu_b;
         3'b011:  res = alu_a | alu_b;
         default: res = alu_a ^ alu_b;
      endcase
   end
   assign alu_result = res;
   assign alu_flags  = {c, (res == 8'h00), res[7], v};

   // Issues one command into an empty FIFO and waits (bounded) for its response.
   task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic [3:0] f, output logic [1:0] s,
                          output int lat);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      r = rsp_result; f = rsp_flags; s = sticky;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_sticky = 1'b1;
      @(negedge clk);
      clr_sticky = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
      rsp_ready = 1'b1; clr_sticky = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
         fails++; $display("FAIL reset_hs: ready/valid=%b expected 10", {cmd_ready, rsp_valid});
      end
      checks++;
      if ({alu_a, alu_b, alu_opcode, rsp_result, rsp_flags} !== 31'd0) begin
         fails++; $display("FAIL reset_data: alu %h %h %h rsp %h %h expected all 0",
                           alu_a, alu_b, alu_opcode, rsp_result, rsp_flags);
      end
      checks++;
      if ({sticky, op_count} !== 18'd0) begin
         fails++; $display("FAIL reset_status: sticky=%b op_count=%0d expected 0", sticky, op_count);
      end
   endtask

   task automatic test_add();
      logic [7:0] r; logic [3:0] f; logic [1:0] s; int lat;
      run_cmd(3'b000, 8'd10, 8'd5, r, f, s, lat);
      checks++;
      if (lat !== 3) begin fails++; $display("FAIL add_latency: got %0d expected 3", lat); end
      checks++;
      if (r !== 8'h0F) begin fails++; $display("FAIL add_result: got %h expected 0f", r); end
      checks++;
      if (f !== 4'b0000) begin fails++; $display("FAIL add_flags: got %b expected 0000", f); end
      checks++;
      if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin
         fails++; $display("FAIL add_count: op_count=%0d valid=%b expected 1,0", op_count, rsp_valid);
      end
   endtask

   task automatic test_sub();
      logic [7:0] r; logic [3:0] f; logic [1:0] s; int lat;
      run_cmd(3'b001, 8'd10, 8'd10, r, f, s, lat);
      checks++;
      if ({r, f} !== {8'h00, 4'b0100}) begin
         fails++; $display("FAIL sub_zero: got %h/%b expected 00/0100", r, f);
      end
      run_cmd(3'b001, 8'd50, 8'd100, r, f, s, lat);
      checks++;
      if ({r, f} !== {8'hCE, 4'b1010}) begin
         fails++; $display("FAIL sub_neg: got %h/%b expected ce/1010", r, f);
      end
      checks++;
      if (sticky !== 2'b10 || op_count !== 16'd3) begin
         fails++; $display("FAIL sub_status: sticky=%b count=%0d expected 10,3", sticky, op_count);
      end
   endtask

   task automatic test_sticky();
      logic [7:0] r; logic [3:0] f; logic [1:0] s; int lat;
      pulse_clr();
      checks++;
      if (sticky !== 2'b00) begin fails++; $display("FAIL sticky_clr1: got %b expected 00", sticky); end
      run_cmd(3'b000, 8'd120, 8'd120, r, f, s, lat);
      checks++;
      if ({r, f} !== {8'hF0, 4'b0011}) begin
         fails++; $display("FAIL add_ovf: got %h/%b expected f0/0011", r, f);
      end
      checks++;
      if (sticky !== 2'b01) begin fails++; $display("FAIL sticky_ovf: got %b expected 01", sticky); end
      run_cmd(3'b000, 8'd1, 8'd1, r, f, s, lat);
      checks++;
      if ({r, f, sticky} !== {8'h02, 4'b0000, 2'b01}) begin
         fails++; $display("FAIL sticky_hold: got %h/%b/%b expected 02/0000/01", r, f, sticky);
      end
      pulse_clr();
      checks++;
      if (sticky !== 2'b00) begin fails++; $display("FAIL sticky_clr2: got %b expected 00", sticky); end
      // Clear held across the capture cycle: the new overflow must still register
      clr_sticky = 1'b1;
      run_cmd(3'b000, 8'd120, 8'd120, r, f, s, lat);
      checks++;
      if (s !== 2'b01) begin fails++; $display("FAIL sticky_set_wins: got %b expected 01", s); end
      clr_sticky = 1'b0;
      @(negedge clk);
      checks++;
      if (sticky !== 2'b00 || op_count !== 16'd6) begin
         fails++; $display("FAIL sticky_after: sticky=%b count=%0d expected 00,6", sticky, op_count);
      end
   endtask

   task automatic test_and();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_opcode = 3'b010; cmd_a = 8'd10; cmd_b = 8'd5;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({alu_opcode, alu_a, alu_b} !== {3'b010, 8'h0A, 8'h05}) begin
            fails++; $display("FAIL and_inputs_stable: cyc %0d got %b %h %h expected 010 0a 05",
                              i, alu_opcode, alu_a, alu_b);
         end
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_result, rsp_flags} !== {1'b1, 8'h00, 4'b0100}) begin
         fails++; $display("FAIL and_rsp: got %b/%h/%b expected 1/00/0100",
                           rsp_valid, rsp_result, rsp_flags);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({alu_a, alu_b, op_count} !== {8'h0A, 8'h05, 16'd7}) begin
         fails++; $display("FAIL and_idle_hold: alu %h %h count %0d expected 0a 05 7",
                           alu_a, alu_b, op_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [18:0] cmds [6];
      logic [11:0] exp_rsp [5];
      logic [11:0] got [8];
      int n;
      int w;
      cmds[0] = {3'b000, 8'd1, 8'd2};       exp_rsp[0] = {8'h03, 4'b0000};
      cmds[1] = {3'b000, 8'd3, 8'd4};       exp_rsp[1] = {8'h07, 4'b0000};
      cmds[2] = {3'b001, 8'd9, 8'd4};       exp_rsp[2] = {8'h05, 4'b0000};
      cmds[3] = {3'b010, 8'hFF, 8'h0F};     exp_rsp[3] = {8'h0F, 4'b0000};
      cmds[4] = {3'b000, 8'd127, 8'd1};     exp_rsp[4] = {8'h80, 4'b0011};
      cmds[5] = {3'b000, 8'd5, 8'd5};
      rsp_ready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; {cmd_opcode, cmd_a, cmd_b} = cmds[0];
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      w = 0;
      while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
      // First command is stalled in the response stage; the next four fill the FIFO
      for (int i = 1; i < 5; i++) begin
         cmd_valid = 1'b1; {cmd_opcode, cmd_a, cmd_b} = cmds[i];
         checks++;
         if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL fill_ready: cmd %0d ready=%b expected 1", i, cmd_ready);
         end
         @(posedge clk);
         @(negedge clk);
      end
      {cmd_opcode, cmd_a, cmd_b} = cmds[5];
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cmd_ready !== 1'b0) begin
            fails++; $display("FAIL full_ready: cyc %0d ready=%b expected 0", i, cmd_ready);
         end
         checks++;
         if ({rsp_valid, rsp_result, rsp_flags} !== {1'b1, exp_rsp[0]}) begin
            fails++; $display("FAIL stall_stable: cyc %0d got %b/%h/%b expected 1/03/0000",
                              i, rsp_valid, rsp_result, rsp_flags);
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (rsp_valid && n < 8) begin
            got[n] = {rsp_result, rsp_flags};
            n++;
         end
         @(negedge clk);
      end
      checks++;
      if (n !== 5) begin fails++; $display("FAIL drain_count: got %0d responses expected 5", n); end
      for (int i = 0; i < 5; i++) begin
         if (i < n) begin
            checks++;
            if (got[i] !== exp_rsp[i]) begin
               fails++; $display("FAIL drain_order: rsp %0d got %h expected %h", i, got[i], exp_rsp[i]);
            end
         end
      end
      checks++;
      if (op_count !== 16'd12 || cmd_ready !== 1'b1) begin
         fails++; $display("FAIL drain_status: count=%0d ready=%b expected 12,1", op_count, cmd_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] r; logic [3:0] f; logic [1:0] s; int lat;
      logic seen;
      @(negedge clk);
      cmd_valid = 1'b1; {cmd_opcode, cmd_a, cmd_b} = {3'b000, 8'd7, 8'd7};
      @(posedge clk);
      @(negedge clk);
      {cmd_opcode, cmd_a, cmd_b} = {3'b000, 8'd8, 8'd8};
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (alu_a !== 8'd7) begin fails++; $display("FAIL mid_drive: alu_a=%h expected 07", alu_a); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_flags, sticky, op_count}
          !== 50'd0 || cmd_ready !== 1'b1) begin
         fails++; $display("FAIL mid_reset_outs: alu %h %h valid %b count %0d ready %b expected 0s,1",
                           alu_a, alu_b, rsp_valid, op_count, cmd_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_rsp: saw rsp_valid=%b expected 0", seen); end
      run_cmd(3'b000, 8'd10, 8'd5, r, f, s, lat);
      checks++;
      if ({r, f} !== {8'h0F, 4'b0000} || lat !== 3 || op_count !== 16'd1) begin
         fails++; $display("FAIL mid_recover: got %h/%b lat %0d count %0d expected 0f/0000 3 1",
                           r, f, lat, op_count);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_sticky();
      test_and();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
